// File: rtl/id_stage_pipe.sv
// Decode stage: write-bypassed register file, immediate generation, control decode,
// load-use hazard detection with a configurable bubble count, and the ID/EX pipeline register.
module id_stage_pipe #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NREG     = 32,
    parameter int unsigned AW       = 5,
    parameter int unsigned LOAD_LAT = 1
) (
    input  logic            clk_50,
    input  logic            rst_i,
    input  logic            init_we,
    input  logic [AW-1:0]   init_addr,
    input  logic [XLEN-1:0] init_data,
    input  logic [31:0]     inst,
    input  logic            inst_valid,
    input  logic            wb_we,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            ex_mem_read,
    input  logic [AW-1:0]   ex_rd_fb,
    input  logic            flush,
    input  logic            hit,
    output logic            stall,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [AW-1:0]   ex_rd,
    output logic [5:0]      ex_ctrl,
    output logic [3:0]      ex_alu_ctrl
);

    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpI      = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLui    = 7'b0110111;

    localparam logic [3:0] AluAnd = 4'b0000;
    localparam logic [3:0] AluOr  = 4'b0001;
    localparam logic [3:0] AluAdd = 4'b0010;
    localparam logic [3:0] AluXor = 4'b0011;
    localparam logic [3:0] AluSll = 4'b0100;
    localparam logic [3:0] AluSrl = 4'b0101;
    localparam logic [3:0] AluSub = 4'b0110;
    localparam logic [3:0] AluSra = 4'b0111;
    localparam logic [3:0] AluSlt = 4'b1000;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            funct7_b5;
    logic            is_lui;
    logic [AW-1:0]   rs1_addr;
    logic [AW-1:0]   rs2_addr;
    logic [AW-1:0]   rd_addr;
    logic [5:0]      ctrl;
    logic [3:0]      alu_ctrl;
    logic [3:0]      alu_func;
    logic            is_r;
    logic            uses_rs2;
    logic [31:0]     imm32;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            rs1_ok;
    logic            rs2_ok;
    logic            wb_ok;
    logic            init_ok;
    logic            hz;
    logic            kill;

    logic [XLEN-1:0] regs_q [NREG];
    logic [2:0]      cnt_q, cnt_d;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] rs1_q, rs1_d;
    logic [XLEN-1:0] rs2_q, rs2_d;
    logic [XLEN-1:0] imm_q, imm_d;
    logic [AW-1:0]   rd_q, rd_d;
    logic [5:0]      ctrl_q, ctrl_d;
    logic [3:0]      alu_q, alu_d;

    assign opcode    = inst[6:0];
    assign funct3    = inst[14:12];
    assign funct7_b5 = inst[30];
    assign is_lui    = (opcode == OpLui);
    assign rs1_addr  = is_lui ? '0 : AW'(inst[19:15]);
    assign rs2_addr  = AW'(inst[24:20]);
    assign rd_addr   = AW'(inst[11:7]);

    // Addresses beyond NREG only exist when the address space is larger than the file.
    if (NREG < (1 << AW)) begin : g_range_check
        assign rs1_ok  = 32'(rs1_addr) < NREG;
        assign rs2_ok  = 32'(rs2_addr) < NREG;
        assign wb_ok   = 32'(wb_rd) < NREG;
        assign init_ok = 32'(init_addr) < NREG;
    end else begin : g_full_range
        assign rs1_ok  = 1'b1;
        assign rs2_ok  = 1'b1;
        assign wb_ok   = 1'b1;
        assign init_ok = 1'b1;
    end

    always_ff @(posedge clk_50 or negedge rst_i) begin
        if (!rst_i) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (init_we) begin
            if (init_ok && init_addr != '0) begin
                regs_q[init_addr] <= init_data;
            end
        end else if (wb_we && wb_ok && wb_rd != '0) begin
            regs_q[wb_rd] <= wb_data;
        end
    end

    always_comb begin
        rs1_data = '0;
        if (rs1_ok && rs1_addr != '0) begin
            rs1_data = (wb_we && wb_rd == rs1_addr) ? wb_data : regs_q[rs1_addr];
        end
        rs2_data = '0;
        if (rs2_ok && rs2_addr != '0) begin
            rs2_data = (wb_we && wb_rd == rs2_addr) ? wb_data : regs_q[rs2_addr];
        end
    end

    assign is_r = (opcode == OpR);

    // Shared R/I function decode; only R-type can select SUB.
    always_comb begin
        alu_func = AluAdd;
        case (funct3)
            3'b000:  alu_func = (is_r && funct7_b5) ? AluSub : AluAdd;
            3'b001:  alu_func = AluSll;
            3'b010:  alu_func = AluSlt;
            3'b011:  alu_func = AluSlt;
            3'b100:  alu_func = AluXor;
            3'b101:  alu_func = funct7_b5 ? AluSra : AluSrl;
            3'b110:  alu_func = AluOr;
            default: alu_func = AluAnd;
        endcase
    end

    always_comb begin
        ctrl     = 6'b000000;
        alu_ctrl = AluAdd;
        imm32    = '0;
        uses_rs2 = 1'b0;
        case (opcode)
            OpR: begin
                ctrl     = 6'b000001;
                alu_ctrl = alu_func;
                uses_rs2 = 1'b1;
            end
            OpI: begin
                ctrl     = 6'b000011;
                alu_ctrl = alu_func;
                imm32    = {{20{inst[31]}}, inst[31:20]};
            end
            OpLoad: begin
                ctrl  = 6'b011011;
                imm32 = {{20{inst[31]}}, inst[31:20]};
            end
            OpStore: begin
                ctrl     = 6'b000110;
                imm32    = {{20{inst[31]}}, inst[31:25], inst[11:7]};
                uses_rs2 = 1'b1;
            end
            OpBranch: begin
                ctrl     = 6'b100000;
                alu_ctrl = AluSub;
                imm32    = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
                uses_rs2 = 1'b1;
            end
            OpLui: begin
                ctrl  = 6'b000011;
                imm32 = {inst[31:12], 12'b0};
            end
            default: ;
        endcase
    end

    assign imm = XLEN'($signed(imm32));

    assign hz = inst_valid & ex_mem_read & (ex_rd_fb != '0) &
                ((ex_rd_fb == rs1_addr) | ((ex_rd_fb == rs2_addr) & uses_rs2));

    // Reset also masks the combinational hazard so PC/IF-ID are released during reset.
    assign stall = rst_i & (hz | (cnt_q != 3'd0));
    assign kill  = flush & ~hit;

    always_comb begin
        cnt_d = cnt_q;
        if (kill) begin
            cnt_d = 3'd0;
        end else if (cnt_q != 3'd0) begin
            cnt_d = cnt_q - 3'd1;
        end else if (hz) begin
            cnt_d = 3'(LOAD_LAT - 1);
        end

        valid_d = 1'b0;
        rs1_d   = '0;
        rs2_d   = '0;
        imm_d   = '0;
        rd_d    = '0;
        ctrl_d  = '0;
        alu_d   = '0;
        if (!kill && !stall) begin
            valid_d = inst_valid;
            rs1_d   = rs1_data;
            rs2_d   = rs2_data;
            imm_d   = imm;
            rd_d    = rd_addr;
            ctrl_d  = inst_valid ? ctrl : 6'b000000;
            alu_d   = alu_ctrl;
        end
    end

    always_ff @(posedge clk_50 or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q   <= 3'd0;
            valid_q <= 1'b0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            imm_q   <= '0;
            rd_q    <= '0;
            ctrl_q  <= '0;
            alu_q   <= '0;
        end else begin
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            imm_q   <= imm_d;
            rd_q    <= rd_d;
            ctrl_q  <= ctrl_d;
            alu_q   <= alu_d;
        end
    end

    assign ex_valid    = valid_q;
    assign ex_rs1_data = rs1_q;
    assign ex_rs2_data = rs2_q;
    assign ex_imm      = imm_q;
    assign ex_rd       = rd_q;
    assign ex_ctrl     = ctrl_q;
    assign ex_alu_ctrl = alu_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: two instances (LOAD_LAT=1 and LOAD_LAT=3) share stimulus.
module tb_id_stage_pipe;

    logic        clk_50 = 1'b0;
    logic        rst_i;
    logic        init_we;
    logic [4:0]  init_addr;
    logic [31:0] init_data;
    logic [31:0] inst;
    logic        inst_valid;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        ex_mem_read;
    logic [4:0]  ex_rd_fb;
    logic        flush;
    logic        hit;

    logic        stall1, valid1;
    logic [31:0] rs1_1, rs2_1, imm1;
    logic [4:0]  rd1;
    logic [5:0]  ctrl1;
    logic [3:0]  alu1;

    logic        stall3, valid3;
    logic [31:0] rs1_3, rs2_3, imm3;
    logic [4:0]  rd3;
    logic [5:0]  ctrl3;
    logic [3:0]  alu3;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_50 = ~clk_50;

    id_stage_pipe #(.XLEN(32), .NREG(32), .AW(5), .LOAD_LAT(1)) u_dut1 (
        .clk_50(clk_50), .rst_i(rst_i), .init_we(init_we), .init_addr(init_addr),
        .init_data(init_data), .inst(inst), .inst_valid(inst_valid), .wb_we(wb_we),
        .wb_rd(wb_rd), .wb_data(wb_data), .ex_mem_read(ex_mem_read), .ex_rd_fb(ex_rd_fb),
        .flush(flush), .hit(hit), .stall(stall1), .ex_valid(valid1), .ex_rs1_data(rs1_1),
        .ex_rs2_data(rs2_1), .ex_imm(imm1), .ex_rd(rd1), .ex_ctrl(ctrl1), .ex_alu_ctrl(alu1)
    );

    id_stage_pipe #(.XLEN(32), .NREG(32), .AW(5), .LOAD_LAT(3)) u_dut3 (
        .clk_50(clk_50), .rst_i(rst_i), .init_we(init_we), .init_addr(init_addr),
        .init_data(init_data), .inst(inst), .inst_valid(inst_valid), .wb_we(wb_we),
        .wb_rd(wb_rd), .wb_data(wb_data), .ex_mem_read(ex_mem_read), .ex_rd_fb(ex_rd_fb),
        .flush(flush), .hit(hit), .stall(stall3), .ex_valid(valid3), .ex_rs1_data(rs1_3),
        .ex_rs2_data(rs2_3), .ex_imm(imm3), .ex_rd(rd3), .ex_ctrl(ctrl3), .ex_alu_ctrl(alu3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk_50);
        #1;
    endtask

    task automatic issue(input logic [31:0] i);
        inst       = i;
        inst_valid = 1'b1;
    endtask

    initial begin
        rst_i = 1'b0; init_we = 1'b0; init_addr = '0; init_data = '0;
        inst = '0; inst_valid = 1'b0; wb_we = 1'b0; wb_rd = '0; wb_data = '0;
        ex_mem_read = 1'b0; ex_rd_fb = '0; flush = 1'b0; hit = 1'b0;

        cyc(); cyc();
        check("rst_valid", 32'(valid1), 32'd0);
        check("rst_ctrl", 32'(ctrl3), 32'd0);
        check("rst_stall", 32'(stall3), 32'd0);

        // addi x1,x0,5
        rst_i = 1'b1;
        issue(32'h0050_0093);
        cyc();
        check("addi_imm", imm1, 32'd5);
        check("addi_ctrl", 32'(ctrl1), 32'b000011);
        check("addi_alu", 32'(alu1), 32'b0010);
        check("addi_rd", 32'(rd1), 32'd1);
        check("addi_valid", 32'(valid3), 32'd1);

        // init beats wb on x2 in the same cycle; bubble in the IF/ID slot
        init_we = 1'b1; init_addr = 5'd2; init_data = 32'hAAAA_0002;
        wb_we = 1'b1; wb_rd = 5'd2; wb_data = 32'hBBBB_0002;
        inst_valid = 1'b0;
        cyc();
        check("bubble_valid", 32'(valid1), 32'd0);
        check("bubble_ctrl", 32'(ctrl1), 32'd0);

        // add x5,x2,x8 while x8 is being initialised (init is not bypassed)
        init_addr = 5'd8; init_data = 32'h1111_2222; wb_we = 1'b0;
        issue(32'h0081_02B3);
        cyc();
        check("init_prio", rs1_1, 32'hAAAA_0002);
        check("init_nobyp", rs2_1, 32'd0);

        // add x4,x3,x3 with write-back of x3 in the same cycle
        init_we = 1'b0;
        wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'hDEAD_0001;
        issue(32'h0031_8233);
        cyc();
        check("byp_rs1", rs1_1, 32'hDEAD_0001);
        check("byp_rs2", rs2_1, 32'hDEAD_0001);
        check("add_ctrl", 32'(ctrl1), 32'b000001);
        check("add_rd", 32'(rd1), 32'd4);

        // write to x0 is dropped and never bypassed
        wb_rd = 5'd0; wb_data = 32'h5555_5555;
        issue(32'h0000_0233);
        cyc();
        check("x0_byp", rs1_1, 32'd0);
        wb_we = 1'b0;
        cyc();
        check("x0_read", rs2_1, 32'd0);

        // lui x10,0x12345 (rs1 field is x8 but must read as 0)
        issue(32'h1234_5537);
        cyc();
        check("lui_imm", imm1, 32'h1234_5000);
        check("lui_rs1", rs1_1, 32'd0);
        check("lui_ctrl", 32'(ctrl1), 32'b000011);
        check("lui_rd", 32'(rd1), 32'd10);

        issue(32'hFFF0_0093);  // addi x1,x0,-1
        cyc();
        check("neg_imm", imm1, 32'hFFFF_FFFF);

        issue(32'h4020_8433);  // sub x8,x1,x2
        cyc();
        check("sub_alu", 32'(alu1), 32'b0110);
        check("sub_rs2", rs2_1, 32'hAAAA_0002);

        issue(32'h4030_D493);  // srai x9,x1,3
        cyc();
        check("srai_alu", 32'(alu1), 32'b0111);
        check("srai_imm", imm1, 32'h0000_0403);

        issue(32'h0020_A423);  // sw x2,8(x1)
        cyc();
        check("sw_ctrl", 32'(ctrl1), 32'b000110);
        check("sw_alu", 32'(alu1), 32'b0010);
        check("sw_imm", imm1, 32'd8);

        issue(32'h0020_8463);  // beq x1,x2,+8
        cyc();
        check("beq_ctrl", 32'(ctrl1), 32'b100000);
        check("beq_alu", 32'(alu1), 32'b0110);
        check("beq_imm", imm1, 32'd8);

        issue(32'h0000_007F);  // undefined opcode
        cyc();
        check("undef_ctrl", 32'(ctrl1), 32'd0);
        check("undef_valid", 32'(valid1), 32'd1);

        // I-type whose rs2 field equals the load destination: no hazard
        ex_mem_read = 1'b1; ex_rd_fb = 5'd5;
        issue(32'h0050_8393);
        #1;
        check("nohz_itype", 32'(stall3), 32'd0);
        cyc();
        check("nohz_valid", 32'(valid3), 32'd1);

        // load destination x0 never hazards
        ex_rd_fb = 5'd0;
        issue(32'h0000_0333);
        #1;
        check("nohz_x0", 32'(stall1), 32'd0);
        cyc();

        // load-use: add x6,x5,x0 after a load to x5
        ex_rd_fb = 5'd5;
        issue(32'h0002_8333);
        #1;
        check("lu_stall1", 32'(stall1), 32'd1);
        check("lu_stall3", 32'(stall3), 32'd1);
        cyc();
        ex_mem_read = 1'b0;
        #1;
        check("lu1_bub", 32'(valid1), 32'd0);
        check("lu1_stall_end", 32'(stall1), 32'd0);
        check("lu3_bub1", 32'(valid3), 32'd0);
        check("lu3_stall2", 32'(stall3), 32'd1);
        cyc();
        check("lu1_issue", 32'(valid1), 32'd1);
        check("lu1_rd", 32'(rd1), 32'd6);
        check("lu3_bub2", 32'(valid3), 32'd0);
        check("lu3_stall3", 32'(stall3), 32'd1);
        cyc();
        check("lu3_bub3", 32'(valid3), 32'd0);
        check("lu3_stall_end", 32'(stall3), 32'd0);
        cyc();
        check("lu3_issue", 32'(valid3), 32'd1);
        check("lu3_rd", 32'(rd3), 32'd6);

        // flush during the second stall cycle of the LOAD_LAT=3 instance
        ex_mem_read = 1'b1;
        #1;
        check("fl_stall0", 32'(stall3), 32'd1);
        cyc();
        ex_mem_read = 1'b0; flush = 1'b1; hit = 1'b0;
        #1;
        check("fl_stall1", 32'(stall3), 32'd1);
        cyc();
        flush = 1'b0;
        #1;
        check("fl_bub3", 32'(valid3), 32'd0);
        check("fl_cnt_clr", 32'(stall3), 32'd0);
        check("fl_bub1", 32'(valid1), 32'd0);
        cyc();
        check("fl_resume", 32'(valid3), 32'd1);

        // flush with hit is ignored
        flush = 1'b1; hit = 1'b1;
        issue(32'h0050_0093);
        cyc();
        check("hit_valid", 32'(valid1), 32'd1);
        check("hit_imm", imm3, 32'd5);
        flush = 1'b0; hit = 1'b0;

        // asynchronous reset mid-cycle with a hazard present
        ex_mem_read = 1'b1; ex_rd_fb = 5'd5;
        issue(32'h0002_8333);
        #1;
        check("pre_rst_stall", 32'(stall1), 32'd1);
        rst_i = 1'b0;
        #1;
        check("arst_valid", 32'(valid1), 32'd0);
        check("arst_imm", imm3, 32'd0);
        check("arst_rd", 32'(rd1), 32'd0);
        check("arst_stall1", 32'(stall1), 32'd0);
        check("arst_stall3", 32'(stall3), 32'd0);

        // registers are cleared by reset
        ex_mem_read = 1'b0;
        rst_i = 1'b1;
        issue(32'h0081_02B3);
        cyc();
        check("rst_reg_x2", rs1_1, 32'd0);
        check("rst_reg_x8", rs2_3, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Parametrised second-generation decode stage for the RV32I-subset pipeline.
- Integrates the register file (write-bypassed), immediate generation, main/ALU control decode, and load-use hazard detection with a configurable stall length.
- Registers its outputs into an internal ID/EX pipeline register, so the EX stage consumes registered operands and a valid bit.
- Sits between the IF/ID register and the EX stage.

Parameters:
- XLEN, 32, datapath/register width; immediates are sign-extended to XLEN.
- NREG, 32, number of architectural registers; x0 is hardwired to zero.
- AW, 5, register address width; AW must be at least clog2(NREG).
- LOAD_LAT, 1, number of bubble cycles inserted per load-use hazard; range 1..7.

Ports:
- clk_50  in  1  system clock; all state updates on its rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- init_we  in  1  debug register-init write enable.
- init_addr  in  AW  debug init address.
- init_data  in  XLEN  debug init data.
- inst  in  32  instruction from the IF/ID register.
- inst_valid  in  1  inst is a real instruction (not a bubble).
- wb_we  in  1  writeback enable.
- wb_rd  in  AW  writeback destination.
- wb_data  in  XLEN  writeback data.
- ex_mem_read  in  1  the instruction now in EX is a load (fed back from ex_ctrl[4]).
- ex_rd_fb  in  AW  destination of the instruction now in EX.
- flush  in  1  branch-resolution flush request.
- hit  in  1  branch prediction was correct; suppresses flush.
- stall  out  1  freezes PC and the IF/ID register; combinational.
- ex_valid  out  1  ID/EX register holds a real instruction.
- ex_rs1_data  out  XLEN  registered rs1 operand.
- ex_rs2_data  out  XLEN  registered rs2 operand.
- ex_imm  out  XLEN  registered sign-extended immediate.
- ex_rd  out  AW  registered destination register.
- ex_ctrl  out  6  registered {Branch, MemRead, MemToReg, MemWrite, ALUSrc, RegWrite}.
- ex_alu_ctrl  out  4  registered ALU operation.

Behaviour:
- Reset (rst_i=0, asynchronous):
  - All ID/EX outputs go to 0; ex_valid=0.
  - Stall counter is cleared.
  - All registers are cleared to 0.
  - stall=0.
- Register file:
  - Writes on the rising edge when wb_we=1 and wb_rd!=0.
  - init_we has priority over wb_we when both are asserted.
  - Reads are combinational.
  - Bypass: if wb_we=1, wb_rd!=0 and wb_rd equals rs1 (or rs2), the read returns wb_data in the same cycle.
  - Reads of x0 always return 0.
  - Reads of an address ≥ NREG return 0; writes to such an address are ignored.
- Decode, by opcode:
  - R-type (0110011): ctrl=000001, ALUOp=R.
  - I-ALU (0010011): ctrl=000011, ALUOp=I.
  - LOAD (0000011): ctrl=011011, ADD.
  - STORE (0100011): ctrl=000110, ADD.
  - BRANCH (1100011): ctrl=100000, SUB.
  - LUI (0110111): ctrl=000011, imm=U-type, rs1 forced to 0, ADD.
  - Any other opcode: ctrl=0.
- ALU control encodings:
  - AND=0000, OR=0001, ADD=0010, XOR=0011, SLL=0100, SRL=0101, SUB=0110, SRA=0111, SLT=1000.
  - SUB is selected only for R-type with funct7[5]=1; SRA is selected by funct7[5] for both R- and I-type shifts.
- Hazard detection:
  - hz = inst_valid & ex_mem_read & (ex_rd_fb!=0) & (ex_rd_fb==rs1 | (ex_rd_fb==rs2 & the opcode uses rs2)).
  - rs2 is used only by R-type, STORE and BRANCH.
- Stall counter (3 bits):
  - On hz with cnt=0, load cnt=LOAD_LAT-1.
  - While cnt>0, decrement each cycle.
  - stall = hz | (cnt!=0).
  - While cnt>0, a new hz is not re-evaluated; the counter is not reloaded.
- ID/EX register update, in priority order:
  1. flush & !hit: load a bubble (ex_valid=0, ex_ctrl=0, ex_alu_ctrl=0; data fields don't-care, driven to 0) and clear cnt to 0.
  2. stall: load a bubble.
  3. Otherwise: load the decoded fields; ex_valid=inst_valid; ex_ctrl=0 when inst_valid=0.
- flush & hit has no effect; hit only gates flush.
- Latency: one cycle from inst to the ex_* outputs.

Test Plan:
- Reset: hold rst_i=0 mid-run → all ex_* outputs = 0 and stall=0 immediately (asynchronous). Release, then issue inst=0x00500093 (addi x1,x0,5) → next cycle ex_imm=5, ex_ctrl=000011, ex_alu_ctrl=0010, ex_rd=1.
- Bypass: wb_we=1, wb_rd=3, wb_data=0xDEAD0001, same cycle inst=add x4,x3,x3 → next cycle ex_rs1_data = ex_rs2_data = 0xDEAD0001. A write to x0 → reads stay 0.
- Load-use, LOAD_LAT=1: ex_mem_read=1, ex_rd_fb=5, inst=add x6,x5,x0 → stall=1 for 1 cycle and one bubble (ex_valid=0). With LOAD_LAT=3 → stall for 3 cycles and 3 bubbles, then the add issues.
- No false hazard: ex_rd_fb=0, or an I-type whose rs2 field matches ex_rd_fb → stall=0.
- Flush: flush=1, hit=0 during the 2nd cycle of a LOAD_LAT=3 stall → bubble loaded, cnt=0, stall drops the next cycle. flush=1, hit=1 → normal decode proceeds.
- Decode sweep: sub (funct7=0100000) → ex_alu_ctrl=0110; srai → 0111; sw → ex_ctrl=000110; beq → ex_ctrl=100000, ex_alu_ctrl=0110; undefined opcode 1111111 → ex_ctrl=0 with ex_valid=1.
